regfile_wb: RTL and testbench

- Write-back end of the MEM/WB stage. Consumes the registered write-back bundle (GPR write plus HI/LO write) and owns the architectural state: 32x32 GPR file and the HI/LO pair.
- Serves two combinational GPR read ports and one HI/LO read port to ID/EX, with same-cycle write-through bypass.
- Keeps a 32-bit retired-write counter for debug.

---
 rtl/regfile_wb_pkg.sv | 11 +
 rtl/regfile_wb_hilo.sv | 53 +++++
 rtl/regfile_wb.sv | 101 ++++++++++
 tb/tb_regfile_wb.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared constants for the write-back register file
package regfile_wb_pkg;

    localparam logic        ENABLE          = 1'b1;
    localparam logic        DISABLE         = 1'b0;
    localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
    localparam int          DEFAULT_DATA_W  = 32;
    localparam int          DEFAULT_ADDR_W  = 5;
    localparam int          DEFAULT_REG_NUM = 32;

endpackage

// File: rtl/regfile_wb_hilo.sv
// rtl/regfile_wb_hilo.sv - HI/LO pair with async clear and write-through bypass
module hilo_reg
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrn_HILO_i,
    input  logic [DATA_W-1:0] wrData_HI_i,
    input  logic [DATA_W-1:0] wrData_LO_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    // HI and LO are only ever written as a pair
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (wrn_HILO_i == ENABLE) begin
            hi_d = wrData_HI_i;
            lo_d = wrData_LO_i;
        end
    end

    // Stored pair; reset wins over any write on a coinciding edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Read side: forced to zero in reset, otherwise the incoming write bypasses the store
    always_comb begin
        hi_o = hi_q;
        lo_o = lo_q;
        if (rst) begin
            hi_o = '0;
            lo_o = '0;
        end else if (wrn_HILO_i == ENABLE) begin
            hi_o = wrData_HI_i;
            lo_o = wrData_LO_i;
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - write-back stage GPR file, HI/LO and retired-write counter
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int REG_NUM = DEFAULT_REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrn_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  logic [DATA_W-1:0] wrData_i,
    input  logic              wrn_HILO_i,
    input  logic [DATA_W-1:0] wrData_HI_i,
    input  logic [DATA_W-1:0] wrData_LO_i,
    input  logic              rdn1_i,
    input  logic [ADDR_W-1:0] rdAddr1_i,
    output logic [DATA_W-1:0] rdData1_o,
    input  logic              rdn2_i,
    input  logic [ADDR_W-1:0] rdAddr2_i,
    output logic [DATA_W-1:0] rdData2_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [31:0]       wbCount_o
);

    logic [DATA_W-1:0] gpr_q [REG_NUM];
    logic [31:0]       wb_count_q, wb_count_d;
    logic              gpr_we;

    // r0 is hardwired to zero, so writes aimed at it never touch the array
    assign gpr_we = (wrn_i == ENABLE) && (wrAddr_i != '0);

    // GPR array; reset clears every entry without waiting for a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (gpr_we) begin
            gpr_q[wrAddr_i] <= wrData_i;
        end
    end

    // Every enabled write retires, including discarded r0 writes; stall bubbles do not
    always_comb begin
        wb_count_d = wb_count_q;
        if (wrn_i == ENABLE) begin
            wb_count_d = wb_count_q + 32'd1;
        end
    end

    // Retired-write counter, wraps naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_count_q <= ZERO_WORD;
        end else begin
            wb_count_q <= wb_count_d;
        end
    end

    assign wbCount_o = wb_count_q;

    // Read port 1: reset, disable and r0 all yield zero ahead of bypass and array lookup
    always_comb begin
        rdData1_o = '0;
        if (rst || (rdn1_i == DISABLE) || (rdAddr1_i == '0)) begin
            rdData1_o = '0;
        end else if ((wrn_i == ENABLE) && (wrAddr_i == rdAddr1_i)) begin
            rdData1_o = wrData_i;
        end else begin
            rdData1_o = gpr_q[rdAddr1_i];
        end
    end

    // Read port 2: identical priority to port 1 so same-address reads always agree
    always_comb begin
        rdData2_o = '0;
        if (rst || (rdn2_i == DISABLE) || (rdAddr2_i == '0)) begin
            rdData2_o = '0;
        end else if ((wrn_i == ENABLE) && (wrAddr_i == rdAddr2_i)) begin
            rdData2_o = wrData_i;
        end else begin
            rdData2_o = gpr_q[rdAddr2_i];
        end
    end

    hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo (
        .clk         (clk),
        .rst         (rst),
        .wrn_HILO_i  (wrn_HILO_i),
        .wrData_HI_i (wrData_HI_i),
        .wrData_LO_i (wrData_LO_i),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

endmodule

// File: tb/tb_regfile_wb.sv
// tb/tb_regfile_wb.sv - directed self-checking bench for regfile_wb
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrn_i;
    logic [4:0]  wrAddr_i;
    logic [31:0] wrData_i;
    logic        wrn_HILO_i;
    logic [31:0] wrData_HI_i;
    logic [31:0] wrData_LO_i;
    logic        rdn1_i;
    logic [4:0]  rdAddr1_i;
    logic [31:0] rdData1_o;
    logic        rdn2_i;
    logic [4:0]  rdAddr2_i;
    logic [31:0] rdData2_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] wbCount_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_wb dut (
        .clk         (clk),
        .rst         (rst),
        .wrn_i       (wrn_i),
        .wrAddr_i    (wrAddr_i),
        .wrData_i    (wrData_i),
        .wrn_HILO_i  (wrn_HILO_i),
        .wrData_HI_i (wrData_HI_i),
        .wrData_LO_i (wrData_LO_i),
        .rdn1_i      (rdn1_i),
        .rdAddr1_i   (rdAddr1_i),
        .rdData1_o   (rdData1_o),
        .rdn2_i      (rdn2_i),
        .rdAddr2_i   (rdAddr2_i),
        .rdData2_o   (rdData2_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .wbCount_o   (wbCount_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_writes();
        wrn_i       = 1'b0;
        wrAddr_i    = 5'd0;
        wrData_i    = 32'h0;
        wrn_HILO_i  = 1'b0;
        wrData_HI_i = 32'h0;
        wrData_LO_i = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wrn_i = 1'b1; wrAddr_i = 5'd5; wrData_i = 32'hFFFF_FFFF;
        wrn_HILO_i = 1'b1; wrData_HI_i = 32'h11; wrData_LO_i = 32'h22;
        rdn1_i = 1'b1; rdAddr1_i = 5'd5; rdn2_i = 1'b1; rdAddr2_i = 5'd5;
        #2;
        n_cmp++; if (rdData1_o !== 32'h0) begin n_fail++; $display("FAIL reset_rd1 got %h exp %h", rdData1_o, 32'h0); end
        n_cmp++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h exp %h", hi_o, 32'h0); end
        step();
        n_cmp++; if (wbCount_o !== 32'h0) begin n_fail++; $display("FAIL reset_edge_count got %h exp %h", wbCount_o, 32'h0); end
        clear_writes();
        rst = 1'b0;
        #1;
        n_cmp++; if (rdData2_o !== 32'h0) begin n_fail++; $display("FAIL reset_edge_nowrite got %h exp %h", rdData2_o, 32'h0); end
        n_cmp++; if (lo_o !== 32'h0) begin n_fail++; $display("FAIL reset_edge_lo got %h exp %h", lo_o, 32'h0); end
    endtask

    task automatic test_bypass();
        wrn_i = 1'b1; wrAddr_i = 5'd3; wrData_i = 32'hDEAD_BEEF;
        rdn1_i = 1'b1; rdAddr1_i = 5'd3;
        #1;
        n_cmp++; if (rdData1_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_same_cycle got %h exp %h", rdData1_o, 32'hDEAD_BEEF); end
        step();
        clear_writes();
        #1;
        n_cmp++; if (rdData1_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_stored got %h exp %h", rdData1_o, 32'hDEAD_BEEF); end
        n_cmp++; if (wbCount_o !== 32'd1) begin n_fail++; $display("FAIL bypass_count got %h exp %h", wbCount_o, 32'd1); end
    endtask

    task automatic test_zero_addr();
        wrn_i = 1'b1; wrAddr_i = 5'd0; wrData_i = 32'hFFFF_FFFF;
        rdn1_i = 1'b1; rdAddr1_i = 5'd0; rdn2_i = 1'b1; rdAddr2_i = 5'd0;
        #1;
        n_cmp++; if (rdData1_o !== 32'h0) begin n_fail++; $display("FAIL r0_bypass_rd1 got %h exp %h", rdData1_o, 32'h0); end
        step();
        clear_writes();
        #1;
        n_cmp++; if (rdData1_o !== 32'h0) begin n_fail++; $display("FAIL r0_rd1 got %h exp %h", rdData1_o, 32'h0); end
        n_cmp++; if (rdData2_o !== 32'h0) begin n_fail++; $display("FAIL r0_rd2 got %h exp %h", rdData2_o, 32'h0); end
        n_cmp++; if (wbCount_o !== 32'd2) begin n_fail++; $display("FAIL r0_count got %h exp %h", wbCount_o, 32'd2); end
    endtask

    task automatic test_port_enable();
        wrn_i = 1'b1; wrAddr_i = 5'd7; wrData_i = 32'h55;
        step();
        clear_writes();
        rdn1_i = 1'b1; rdAddr1_i = 5'd7; rdn2_i = 1'b0; rdAddr2_i = 5'd7;
        #1;
        n_cmp++; if (rdData1_o !== 32'h55) begin n_fail++; $display("FAIL en_rd1 got %h exp %h", rdData1_o, 32'h55); end
        n_cmp++; if (rdData2_o !== 32'h0) begin n_fail++; $display("FAIL en_rd2_disabled got %h exp %h", rdData2_o, 32'h0); end
        rdn2_i = 1'b1;
        #1;
        n_cmp++; if (rdData2_o !== 32'h55) begin n_fail++; $display("FAIL en_rd2_same_addr got %h exp %h", rdData2_o, 32'h55); end
        n_cmp++; if (wbCount_o !== 32'd3) begin n_fail++; $display("FAIL en_count got %h exp %h", wbCount_o, 32'd3); end
    endtask

    task automatic test_hilo();
        wrn_HILO_i = 1'b1; wrData_HI_i = 32'h1; wrData_LO_i = 32'h2;
        wrn_i = 1'b1; wrAddr_i = 5'd9; wrData_i = 32'h99;
        #1;
        n_cmp++; if (hi_o !== 32'h1) begin n_fail++; $display("FAIL hilo_bypass_hi got %h exp %h", hi_o, 32'h1); end
        n_cmp++; if (lo_o !== 32'h2) begin n_fail++; $display("FAIL hilo_bypass_lo got %h exp %h", lo_o, 32'h2); end
        step();
        clear_writes();
        wrData_HI_i = 32'hBAD0; wrData_LO_i = 32'hBAD1;
        rdn1_i = 1'b1; rdAddr1_i = 5'd9;
        #1;
        n_cmp++; if (hi_o !== 32'h1) begin n_fail++; $display("FAIL hilo_held_hi got %h exp %h", hi_o, 32'h1); end
        n_cmp++; if (lo_o !== 32'h2) begin n_fail++; $display("FAIL hilo_held_lo got %h exp %h", lo_o, 32'h2); end
        n_cmp++; if (rdData1_o !== 32'h99) begin n_fail++; $display("FAIL hilo_gpr_r9 got %h exp %h", rdData1_o, 32'h99); end
        n_cmp++; if (wbCount_o !== 32'd4) begin n_fail++; $display("FAIL hilo_count got %h exp %h", wbCount_o, 32'd4); end
    endtask

    task automatic test_async_reset();
        wrn_i = 1'b1; wrAddr_i = 5'd5; wrData_i = 32'h1234_5678;
        wrn_HILO_i = 1'b1; wrData_HI_i = 32'hAA; wrData_LO_i = 32'hBB;
        step();
        clear_writes();
        rdn1_i = 1'b1; rdAddr1_i = 5'd5; rdn2_i = 1'b1; rdAddr2_i = 5'd3;
        #1;
        n_cmp++; if (rdData1_o !== 32'h1234_5678) begin n_fail++; $display("FAIL arst_pre_r5 got %h exp %h", rdData1_o, 32'h1234_5678); end
        n_cmp++; if (hi_o !== 32'hAA) begin n_fail++; $display("FAIL arst_pre_hi got %h exp %h", hi_o, 32'hAA); end
        n_cmp++; if (wbCount_o !== 32'd5) begin n_fail++; $display("FAIL arst_pre_count got %h exp %h", wbCount_o, 32'd5); end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (rdData1_o !== 32'h0) begin n_fail++; $display("FAIL arst_rd1 got %h exp %h", rdData1_o, 32'h0); end
        n_cmp++; if (rdData2_o !== 32'h0) begin n_fail++; $display("FAIL arst_rd2 got %h exp %h", rdData2_o, 32'h0); end
        n_cmp++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL arst_hi got %h exp %h", hi_o, 32'h0); end
        n_cmp++; if (lo_o !== 32'h0) begin n_fail++; $display("FAIL arst_lo got %h exp %h", lo_o, 32'h0); end
        n_cmp++; if (wbCount_o !== 32'h0) begin n_fail++; $display("FAIL arst_count got %h exp %h", wbCount_o, 32'h0); end
        step();
        rst = 1'b0;
        #1;
        n_cmp++; if (rdData1_o !== 32'h0) begin n_fail++; $display("FAIL arst_post_r5 got %h exp %h", rdData1_o, 32'h0); end
        n_cmp++; if (rdData2_o !== 32'h0) begin n_fail++; $display("FAIL arst_post_r3 got %h exp %h", rdData2_o, 32'h0); end
        n_cmp++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL arst_post_hi got %h exp %h", hi_o, 32'h0); end
        n_cmp++; if (wbCount_o !== 32'h0) begin n_fail++; $display("FAIL arst_post_count got %h exp %h", wbCount_o, 32'h0); end
    endtask

    task automatic test_count_wrap();
        force dut.wb_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.wb_count_q;
        wrn_i = 1'b1; wrAddr_i = 5'd1; wrData_i = 32'h77;
        step();
        n_cmp++; if (wbCount_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_max got %h exp %h", wbCount_o, 32'hFFFF_FFFF); end
        step();
        clear_writes();
        #1;
        n_cmp++; if (wbCount_o !== 32'h0) begin n_fail++; $display("FAIL wrap_zero got %h exp %h", wbCount_o, 32'h0); end
        step();
        n_cmp++; if (wbCount_o !== 32'h0) begin n_fail++; $display("FAIL wrap_bubble got %h exp %h", wbCount_o, 32'h0); end
    endtask

    initial begin
        clear_writes();
        rdn1_i = 1'b0; rdAddr1_i = 5'd0; rdn2_i = 1'b0; rdAddr2_i = 5'd0;
        test_reset();
        test_bypass();
        test_zero_addr();
        test_port_enable();
        test_hilo();
        test_async_reset();
        test_count_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
